// File: rtl/fifo_wr_gen_if.sv
// fifo_wr_gen_if
//   Bundle of the generator's control, FIFO flag and write-port signals.
//   Signals:
//     enable, mode        run request and traffic mode (from the controller)
//     wr_full, wr_empty   FIFO flags in the write-clock domain
//     wr_req, wr_data     FIFO write strobe and write data
//     busy, burst_done    generator status
//     wr_cnt              total accepted writes since reset
//   Modports:
//     master  the generator (fifo_wr_gen)
//     slave   the environment: controller plus FIFO
interface fifo_wr_gen_if #(
  parameter int unsigned DATA_W = 32'd8
) ();
  logic              enable;
  logic [1:0]        mode;
  logic              wr_full;
  logic              wr_empty;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              burst_done;
  logic [31:0]       wr_cnt;

  modport master (
    input  enable, mode, wr_full, wr_empty,
    output wr_req, wr_data, busy, burst_done, wr_cnt
  );

  modport slave (
    output enable, mode, wr_full, wr_empty,
    input  wr_req, wr_data, busy, burst_done, wr_cnt
  );
endinterface

// File: rtl/fifo_wr_gen.sv
// fifo_wr_gen
//   FIFO write-side traffic generator. It supports three traffic modes:
//   fill-on-empty (0), fixed burst of BURST_LEN words (1) and continuous (2).
//   Mode 3 behaves as mode 0.
//   Ports:
//     clk    system clock (single domain)
//     rst_n  asynchronous active-low reset
//     bus    fifo_wr_gen_if.master: enable/mode/wr_full/wr_empty in;
//            wr_req (combinational), wr_data, busy, burst_done, wr_cnt out
//   Build option:
//     FIFO_WR_LFSR_EN  if defined, the data pattern is a DATA_W-bit Galois
//                      LFSR with mask LFSR_TAPS. If undefined, the data
//                      pattern is an incrementing counter.
module fifo_wr_gen #(
  parameter int unsigned DATA_W    = 32'd8,
  parameter int unsigned BURST_LEN = 32'd16,
  parameter int unsigned START_VAL = 32'd0,
  parameter int unsigned LFSR_TAPS = 32'h0000_00B8
) (
  input logic          clk,
  input logic          rst_n,
  fifo_wr_gen_if.master bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EMPTY = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [15:0]       BURST_LAST = 16'(BURST_LEN - 32'd1);
  localparam logic [DATA_W-1:0] START_W    = START_VAL[DATA_W-1:0];
  localparam logic [DATA_W-1:0] ONE_W      = {{(DATA_W-1){1'b0}}, 1'b1};

`ifdef FIFO_WR_LFSR_EN
  // An all-zero seed would lock the LFSR, so zero is replaced by 1.
  localparam logic [DATA_W-1:0] SEED = (START_W == '0) ? ONE_W : START_W;
  localparam logic [DATA_W-1:0] TAPS = LFSR_TAPS[DATA_W-1:0];
`else
  localparam logic [DATA_W-1:0] SEED = START_W;
`endif

  // Reject parameter values the datapath cannot represent.
  if (DATA_W < 32'd2 || DATA_W > 32'd32) begin : g_bad_data_w
    $error("fifo_wr_gen: DATA_W must be in 2..32");
  end
  if (BURST_LEN < 32'd1 || BURST_LEN > 32'd65535) begin : g_bad_burst_len
    $error("fifo_wr_gen: BURST_LEN must be in 1..65535");
  end
  if (DATA_W < 32'd32 && (LFSR_TAPS >> DATA_W) != 32'd0) begin : g_wide_taps
    $warning("fifo_wr_gen: LFSR_TAPS bits above DATA_W are ignored");
  end

  // Next value of the data pattern after an accepted write.
  function automatic logic [DATA_W-1:0] pattern_next(input logic [DATA_W-1:0] v);
`ifdef FIFO_WR_LFSR_EN
    pattern_next = {1'b0, v[DATA_W-1:1]} ^ (v[0] ? TAPS : '0);
`else
    pattern_next = v + ONE_W;
`endif
  endfunction

  state_t            state_r, state_nxt_s;
  logic [1:0]        mode_r;
  logic              rearm_wait_r;   // burst finished; wait for enable low
  logic [15:0]       burst_cnt_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [31:0]       wr_cnt_r;
  logic              busy_r;
  logic              burst_done_r;
  logic              done_nxt_s;
  logic              wr_req_s;
  logic              start_s;
  logic              reload_s;
  logic              enter_write_s;

  assign wr_req_s = (state_r == WRITE) && bus.enable && !bus.wr_full;
  assign start_s  = (state_r == IDLE) && bus.enable && !rearm_wait_r;

  // Next-state decode and burst_done pulse request.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    if (!bus.enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            if (bus.mode == 2'd1 || bus.mode == 2'd2) begin
              state_nxt_s = WRITE;
            end else begin
              state_nxt_s = WAIT_EMPTY;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WAIT_EMPTY: begin
          // A FIFO that reports full and empty together is treated as full.
          if (bus.wr_empty && !bus.wr_full) begin
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s = WAIT_EMPTY;
          end
        end
        WRITE: begin
          case (mode_r)
            2'd1: begin
              if (wr_req_s && burst_cnt_r == BURST_LAST) begin
                state_nxt_s = DONE;
                done_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = WRITE;
              end
            end
            2'd2: begin
              state_nxt_s = WRITE;
            end
            default: begin
              if (bus.wr_full) begin
                state_nxt_s = WAIT_EMPTY;
                done_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = WRITE;
              end
            end
          endcase
        end
        DONE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  assign reload_s      = (state_r == WAIT_EMPTY) && (state_nxt_s == WRITE);
  assign enter_write_s = (state_r != WRITE) && (state_nxt_s == WRITE);

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      burst_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      burst_done_r <= done_nxt_s;
    end
  end

  // Mode latch on start and the rearm flag that blocks back-to-back bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r       <= 2'd0;
      rearm_wait_r <= 1'b0;
    end else begin
      if (start_s) begin
        mode_r <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
      end
      if (!bus.enable) begin
        rearm_wait_r <= 1'b0;
      end else if (state_r == DONE) begin
        rearm_wait_r <= 1'b1;
      end
    end
  end

  // Burst word counter: cleared while disabled and on each entry to WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= 16'd0;
    end else if (!bus.enable || enter_write_s) begin
      burst_cnt_r <= 16'd0;
    end else if (wr_req_s) begin
      burst_cnt_r <= burst_cnt_r + 16'd1;
    end
  end

  // Data pattern and total write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data_r <= SEED;
      wr_cnt_r  <= 32'd0;
    end else begin
      if (reload_s) begin
        wr_data_r <= SEED;
      end else if (wr_req_s) begin
        wr_data_r <= pattern_next(wr_data_r);
      end
      if (wr_req_s) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
    end
  end

  assign bus.wr_req     = wr_req_s;
  assign bus.wr_data    = wr_data_r;
  assign bus.busy       = busy_r;
  assign bus.burst_done = burst_done_r;
  assign bus.wr_cnt     = wr_cnt_r;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// tb_fifo_wr_gen
//   Directed bench for fifo_wr_gen (DATA_W=8, BURST_LEN=16, START_VAL=0).
//   Expected write data is queued when a phase is started and popped each
//   time the generator issues wr_req.
module tb_fifo_wr_gen;

  logic clk;
  logic rst_n;

  bit   full_force;
  bit   empty_force;
  bit   fifo_model_en;
  int   fifo_cnt;

  int   n_tests;
  int   n_fail;
  int   done_cnt;
  logic [7:0] sb_q[$];
  logic [7:0] mdl_v;

  fifo_wr_gen_if #(.DATA_W(8)) bus ();

  fifo_wr_gen #(
    .DATA_W   (8),
    .BURST_LEN(16),
    .START_VAL(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // 64-deep FIFO model without reads, or directly forced flags.
  assign bus.wr_full  = full_force | (fifo_model_en & (fifo_cnt >= 64));
  assign bus.wr_empty = fifo_model_en ? (fifo_cnt == 0) : empty_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIFO_WR_LFSR_EN
  localparam logic [7:0] SEED = 8'h01;
  function automatic logic [7:0] exp_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction
`else
  localparam logic [7:0] SEED = 8'h00;
  function automatic logic [7:0] exp_next(input logic [7:0] v);
    return v + 8'd1;
  endfunction
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(mdl_v);
      mdl_v = exp_next(mdl_v);
    end
  endtask

  // One clock: sample at negedge, score writes, advance FIFO model after edge.
  task automatic step(output bit req_o);
    @(negedge clk);
    req_o = bus.wr_req;
    if (bus.burst_done) done_cnt++;
    if (req_o) begin
      check("sb_expected_write", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) check("wr_data", bus.wr_data, sb_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (req_o && fifo_model_en) fifo_cnt++;
  endtask

  task automatic run_writes(input int n, input int budget, input string tag);
    int got = 0;
    bit r;
    for (int c = 0; c < budget && got < n; c++) begin
      step(r);
      if (r) got++;
    end
    check(tag, got, n);
  endtask

  task automatic idle_steps(input int n);
    bit r;
    for (int i = 0; i < n; i++) step(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    int w;
    int d0;
    n_tests = 0; n_fail = 0; done_cnt = 0;
    full_force = 1'b0; empty_force = 1'b0; fifo_model_en = 1'b0; fifo_cnt = 0;
    mdl_v = SEED;
    bus.enable = 1'b1;
    bus.mode   = 2'd1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_req", bus.wr_req, 1'b0);
    check("rst_wr_data", bus.wr_data, SEED);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_burst_done", bus.burst_done, 1'b0);
    check("rst_wr_cnt", bus.wr_cnt, 32'd0);

    // Mode 1 from reset release with enable held high.
    rst_n = 1'b1;
    push_n(16);
    step(r); check("t1_latency_c0", r, 1'b0);
    step(r); check("t1_latency_c1", r, 1'b1);
    run_writes(15, 30, "t1_writes");
    check("t1_done_pulse", bus.burst_done, 1'b1);
    step(r);
    check("t1_done_single", bus.burst_done, 1'b0);
    idle_steps(4);
    check("t1_done_count", done_cnt, 1);
    check("t1_busy_idle", bus.busy, 1'b0);
    check("t1_wr_cnt", bus.wr_cnt, 32'd16);
    check("t1_sb_empty", sb_q.size(), 0);

    // Mode 2 with a 5-cycle full stall mid-stream.
    bus.enable = 1'b0;
    step(r);
    bus.mode = 2'd2;
    bus.enable = 1'b1;
    push_n(20);
    step(r); check("t2_latency", r, 1'b0);
    run_writes(10, 15, "t2_writes_a");
    full_force = 1'b1;
    #1 check("t2_req_drop_comb", bus.wr_req, 1'b0);
    w = 0;
    for (int i = 0; i < 5; i++) begin step(r); w += int'(r); end
    check("t2_stall_writes", w, 0);
    full_force = 1'b0;
    #1 check("t2_req_resume_comb", bus.wr_req, 1'b1);
    run_writes(10, 15, "t2_writes_b");
    check("t2_sb_empty", sb_q.size(), 0);

    // Asynchronous reset in the middle of a continuous stream.
    push_n(3);
    run_writes(3, 6, "t5_writes");
    check("t5_wr_cnt_pre", bus.wr_cnt, 32'd39);
    check("t5_req_pre", bus.wr_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_async", bus.wr_req, 1'b0);
    check("t5_data_async", bus.wr_data, SEED);
    check("t5_cnt_async", bus.wr_cnt, 32'd0);
    check("t5_busy_async", bus.busy, 1'b0);
    sb_q.delete();
    mdl_v = SEED;
    bus.enable = 1'b0;
    bus.mode = 2'd1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mode 1 burst interrupted after 7 writes, then a fresh 16-word burst.
    bus.enable = 1'b1;
    push_n(7);
    run_writes(7, 12, "t4_writes_a");
    bus.enable = 1'b0;
    step(r);
    check("t4_gated_req", r, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_hold_data", bus.wr_data, mdl_v);
    check("t4_hold_cnt", bus.wr_cnt, 32'd7);
    d0 = done_cnt;
    bus.enable = 1'b1;
    push_n(16);
    run_writes(16, 30, "t4_writes_b");
    idle_steps(3);
    check("t4_done_count", done_cnt, d0 + 1);
    check("t4_next_data", bus.wr_data, mdl_v);
    check("t4_sb_empty", sb_q.size(), 0);

    // Mode 0 against a 64-deep FIFO with no reads, then restart after drain.
    bus.enable = 1'b0;
    step(r);
    fifo_model_en = 1'b1;
    fifo_cnt = 0;
    bus.mode = 2'd0;
    bus.enable = 1'b1;
    mdl_v = SEED;
    push_n(64);
    d0 = done_cnt;
    step(r); check("t3_latency_c0", r, 1'b0);
    step(r); check("t3_latency_c1", r, 1'b0);
    run_writes(64, 80, "t3_fill_writes");
    check("t3_fifo_level", fifo_cnt, 64);
    idle_steps(4);
    check("t3_done_count", done_cnt, d0 + 1);
    check("t3_busy_wait", bus.busy, 1'b1);
    fifo_cnt = 0;
    mdl_v = SEED;
    push_n(4);
    run_writes(4, 10, "t3_restart_writes");
    check("t3_wr_cnt", bus.wr_cnt, 32'd91);

    // Mode 3 (as mode 0) with full and empty both high: no writes.
    bus.enable = 1'b0;
    step(r);
    fifo_model_en = 1'b0;
    empty_force = 1'b1;
    full_force = 1'b1;
    bus.mode = 2'd3;
    bus.enable = 1'b1;
    w = 0;
    for (int i = 0; i < 6; i++) begin step(r); w += int'(r); end
    check("t6_full_wins", w, 0);
    check("t6_busy_wait", bus.busy, 1'b1);
    full_force = 1'b0;
    mdl_v = SEED;
    push_n(3);
    run_writes(3, 10, "t6_writes");
    bus.enable = 1'b0;
    step(r);
    check("t6_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_gen.md
# fifo_wr_gen

Parametrised FIFO write-side traffic generator, the successor to the fixed 8-bit fill-on-empty writer. It drives the write port of a FIFO (IP or in-house) with a deterministic data pattern. It supports three traffic modes: fill-on-empty, fixed burst and continuous. It sits beside the FIFO in loopback/self-test designs and feeds the paired read-side checker.

## Interface
Parameters:
- DATA_W, 8, width of wr_data (2..32)
- BURST_LEN, 16, words per burst in mode 1 (1..65535)
- START_VAL, 0, first data word after reset / pattern restart
- LFSR_TAPS, 8'hB8, Galois LFSR feedback mask, DATA_W bits (used only with FIFO_WR_LFSR_EN)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; level sensitive
- mode  in  2  0 = fill-on-empty, 1 = fixed burst, 2 = continuous, 3 = reserved (treated as 0)
- wr_full  in  1  FIFO full flag, write-clock domain
- wr_empty  in  1  FIFO empty flag, write-clock domain
- wr_req  out  1  write strobe (combinational)
- wr_data  out  DATA_W  write data (registered)
- busy  out  1  high in any state other than IDLE
- burst_done  out  1  one-cycle pulse: mode-1 burst complete, or mode-0 fill complete
- wr_cnt  out  32  total accepted writes since reset; wraps at 2^32

## Operation
- An accepted write is a cycle with wr_req = 1. wr_req = (state == WRITE) & enable & ~wr_full. The generator never writes into a full FIFO.
- States: IDLE, WAIT_EMPTY, WRITE, DONE.
- IDLE:
  - Entered when enable = 0.
  - When enable = 1, mode is latched into an internal register; mode changes at any other time are ignored.
  - Latched mode 0 → WAIT_EMPTY. Latched mode 1 or 2 → WRITE.
- WAIT_EMPTY: wr_empty = 1 → WRITE, and wr_data reloads START_VAL.
- WRITE:
  - Mode 0: wr_full = 1 → WAIT_EMPTY, with burst_done pulsed.
  - Mode 1: the accepted write that brings the burst counter to BURST_LEN → DONE.
  - Mode 2: stays in WRITE indefinitely and stalls while full.
- DONE: pulses burst_done for one cycle, then goes to IDLE. A new burst needs enable low for at least one cycle, then high again.
- enable = 0 in any state → IDLE on the next edge. The burst counter clears; wr_data and wr_cnt hold.
- Data pattern (default build):
  - wr_data increments by 1 modulo 2^DATA_W on each accepted write.
  - Mode 0 restarts at START_VAL for each fill.
  - Modes 1 and 2 continue from the last value across bursts.
- Burst counter is 16 bits. It clears on entry to WRITE.

## Timing
- Reset values: wr_req 0, wr_data START_VAL, busy 0, burst_done 0, wr_cnt 0, state IDLE, latched mode 0.
- wr_req responds combinationally to wr_full and enable in the same cycle.
- wr_data is valid in the same cycle as wr_req. It advances on the edge that ends an accepted write.
- Latency from enable rising to the first wr_req:
  - Modes 1/2: 1 cycle.
  - Mode 0: 1 cycle after wr_empty is seen in WAIT_EMPTY, i.e. at least 2 cycles.
- Mode 1 produces exactly BURST_LEN accepted writes. burst_done is asserted 1 cycle after the last write.
- Simultaneous conditions:
  - wr_empty and wr_full both high (broken FIFO): full wins; no write is issued.
  - enable falling in the same cycle as a mode-1 final write: that write is not issued, because wr_req is gated by enable; the state goes to IDLE.
- Asynchronous reset mid-burst: all outputs go to their reset values immediately. wr_req drops combinationally.
- wr_cnt increments on every accepted write, in all modes.

## Configuration
- FIFO_WR_LFSR_EN defined:
  - The pattern is a DATA_W-bit Galois LFSR.
  - Next value = (v >> 1) ^ (v[0] ? LFSR_TAPS : 0).
  - It is seeded with START_VAL, or 1 if START_VAL = 0.
  - It advances on each accepted write; mode-0 reload restores the seed.
- Undefined: incrementing counter as described in Operation. LFSR_TAPS is unused.

## Test plan
- Reset release, mode 1, BURST_LEN = 16, FIFO never full, enable held → exactly 16 wr_req cycles with data 0..15, one burst_done pulse, wr_cnt = 16, then busy = 0 while enable stays high.
- Mode 0, 64-deep FIFO model with no reads → WAIT_EMPTY, then 64 writes of data 0..63, wr_full, burst_done. After the model drains to empty, data restarts at 0.
- Mode 2 with wr_full forced high for 5 cycles mid-stream → wr_req low for exactly those 5 cycles, and data resumes at the next value with no gap or repeat.
- enable dropped after 7 of 16 mode-1 writes → IDLE next cycle, wr_data = 7. On re-enable, 16 fresh writes with data 7..22.
- rst_n asserted asynchronously during WRITE → wr_req drops in the same cycle, wr_data = START_VAL, wr_cnt = 0.
- Build with FIFO_WR_LFSR_EN, DATA_W = 8, START_VAL = 0 → sequence 0x01, 0xB8, 0x5C, 0x2E…
